// File: rtl/ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg -- shared constants for the multi-port data RAM.
//
// Contents:
//   RDW_OLD / RDW_NEW   same-address read-during-write behaviour selectors
//   RD_LAT_MIN/MAX      legal range of the read latency parameter
//   NPORTS_MIN/MAX      legal range of the port-count parameter
// -----------------------------------------------------------------------------
package ram_pkg;

  // Read-during-write: return the word as it was before the write, or the
  // merged word with the strobed bytes already replaced.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Read latency in cycles from grant edge to rvalid.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Number of independent access ports.
  localparam int NPORTS_MIN = 1;
  localparam int NPORTS_MAX = 4;

endpackage : ram_pkg

// File: rtl/ram_bank.sv
// -----------------------------------------------------------------------------
// ram_bank -- NPORTS-port, byte-strobed storage array with no reset.
//
// Every port has a combinational read path and a byte-strobed write path that
// commits on the rising clock edge. The caller guarantees that no two enabled
// write ports target the same address in one cycle, so write order between
// ports never matters.
//
// Ports:
//   clk        rising-edge clock
//   wen        per-port write enable (already arbitrated)
//   wstrb      per-port byte enables, port p uses [p*SW +: SW]
//   addr       per-port word address, port p uses [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata      per-port write data,   port p uses [p*DATA_WIDTH +: DATA_WIDTH]
//   rdata_raw  per-port combinational read of the array (pre-write contents)
// -----------------------------------------------------------------------------
module ram_bank #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NPORTS     = 2
) (
  input  logic                           clk,
  input  logic [NPORTS-1:0]              wen,
  input  logic [NPORTS*DATA_WIDTH/8-1:0] wstrb,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]   wdata,
  output logic [NPORTS*DATA_WIDTH-1:0]   rdata_raw
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // NOTE: the storage array has no reset: clearing thousands of words would
  // need a reset fan-out to every cell and block mapping onto RAM macros.
  // The declaration initialiser gives all-zero contents at simulation start.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    assign rdata_raw[p*DATA_WIDTH +: DATA_WIDTH] = mem[addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
  end

  // NOTE: sequential state uses non-blocking assignments so every read of
  // mem in the same time step sees the pre-edge contents.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (wen[p]) begin
        for (int b = 0; b < SW; b++) begin
          if (wstrb[p*SW + b]) begin
            mem[addr[p*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <= wdata[p*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule : ram_bank

// File: rtl/data_ram_mp.sv
// -----------------------------------------------------------------------------
// data_ram_mp -- multi-port data RAM with write-collision arbitration,
// selectable read-during-write behaviour and a 1- or 2-cycle read pipeline.
//
// Parameters:
//   ADDR_WIDTH  word-address width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  word width, multiple of 8 (SW = DATA_WIDTH/8 strobe bits)
//   NPORTS      number of ports, 1..4
//   RD_LATENCY  grant-to-rvalid latency, 1 or 2
//   RDW_MODE    RDW_OLD: same-cycle read sees old word; RDW_NEW: merged word
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req, we     per-port request and write(1)/read(0) select
//   wstrb       per-port byte enables   [p*SW +: SW]
//   addr        per-port word address   [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata       per-port write data     [p*DATA_WIDTH +: DATA_WIDTH]
//   gnt         per-port grant, combinational from the current inputs
//   rdata       per-port read data, holds between rvalid pulses
//   rvalid      per-port one-cycle read-data valid pulse
// -----------------------------------------------------------------------------
module data_ram_mp
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NPORTS     = 2,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NPORTS-1:0]              req,
  input  logic [NPORTS-1:0]              we,
  input  logic [NPORTS*DATA_WIDTH/8-1:0] wstrb,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NPORTS*DATA_WIDTH-1:0]   wdata,
  output logic [NPORTS-1:0]              gnt,
  output logic [NPORTS*DATA_WIDTH-1:0]   rdata,
  output logic [NPORTS-1:0]              rvalid
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // Parameter legality, rejected at elaboration.
  // ---------------------------------------------------------------------------
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("data_ram_mp: DATA_WIDTH must be a positive multiple of 8");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("data_ram_mp: ADDR_WIDTH must be at least 1");
  end
  if (NPORTS < NPORTS_MIN || NPORTS > NPORTS_MAX) begin : g_bad_nports
    $error("data_ram_mp: NPORTS must be in 1..4");
  end
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("data_ram_mp: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw_mode
    $error("data_ram_mp: RDW_MODE must be RDW_OLD (0) or RDW_NEW (1)");
  end

  // ---------------------------------------------------------------------------
  // Write-collision arbitration: a write loses only to a lower-index port that
  // is also requesting a write to the same word. Reads are never stalled.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt = req;
    for (int p = 1; p < NPORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (req[q] && we[q] && we[p] &&
            addr[q*AW +: AW] == addr[p*AW +: AW]) begin
          gnt[p] = 1'b0;
        end
      end
    end
  end

  logic [NPORTS-1:0] wr_fire;
  logic [NPORTS-1:0] rd_fire;

  assign wr_fire = gnt & req & we;
  assign rd_fire = gnt & req & ~we;

  // ---------------------------------------------------------------------------
  // Storage.
  // ---------------------------------------------------------------------------
  logic [NPORTS*DW-1:0] rdata_raw;

  ram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NPORTS     (NPORTS)
  ) u_bank (
    .clk       (clk),
    .wen       (wr_fire),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .rdata_raw (rdata_raw)
  );

  // ---------------------------------------------------------------------------
  // Read-during-write bypass. The array read is pre-write by construction;
  // in RDW_NEW mode the strobed bytes of any same-cycle granted write to the
  // same word are overlaid. Arbitration guarantees at most one such write.
  // ---------------------------------------------------------------------------
  logic [NPORTS*DW-1:0] rd_word;

  always_comb begin
    rd_word = rdata_raw;
    if (RDW_MODE == RDW_NEW) begin
      for (int p = 0; p < NPORTS; p++) begin
        for (int w = 0; w < NPORTS; w++) begin
          if (wr_fire[w] && addr[w*AW +: AW] == addr[p*AW +: AW]) begin
            for (int b = 0; b < SW; b++) begin
              if (wstrb[w*SW + b]) begin
                rd_word[p*DW + b*8 +: 8] = wdata[w*DW + b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First read stage: captures the word on the grant edge. Data only loads on
  // a read pulse so rdata holds between pulses.
  // ---------------------------------------------------------------------------
  logic [NPORTS-1:0]    rv_s1;
  logic [NPORTS*DW-1:0] rd_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_s1 <= '0;
      rd_s1 <= '0;
    end else begin
      rv_s1 <= rd_fire;
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_fire[p]) begin
          rd_s1[p*DW +: DW] <= rd_word[p*DW +: DW];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional second stage: a pure output register behind stage one.
  // ---------------------------------------------------------------------------
  if (RD_LATENCY == 2) begin : g_lat2
    logic [NPORTS-1:0]    rv_s2;
    logic [NPORTS*DW-1:0] rd_s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv_s2 <= '0;
        rd_s2 <= '0;
      end else begin
        rv_s2 <= rv_s1;
        for (int p = 0; p < NPORTS; p++) begin
          if (rv_s1[p]) begin
            rd_s2[p*DW +: DW] <= rd_s1[p*DW +: DW];
          end
        end
      end
    end

    assign rvalid = rv_s2;
    assign rdata  = rd_s2;
  end else begin : g_lat1
    assign rvalid = rv_s1;
    assign rdata  = rd_s1;
  end

endmodule : data_ram_mp

// File: tb/tb_data_ram_mp.sv
// -----------------------------------------------------------------------------
// tb_data_ram_mp -- directed bench for data_ram_mp.
//
// Three instances share one stimulus stream:
//   u_old   RD_LATENCY=1, RDW_MODE=0 (old data on same-cycle read)
//   u_new   RD_LATENCY=1, RDW_MODE=1 (merged new data on same-cycle read)
//   u_lat2  RD_LATENCY=2, RDW_MODE=0
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled 1 time unit after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_data_ram_mp;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req;
  logic [NP-1:0]     we;
  logic [NP*SW-1:0]  wstrb;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;

  logic [NP-1:0]     gnt_a, gnt_b, gnt_c;
  logic [NP*DW-1:0]  rdata_a, rdata_b, rdata_c;
  logic [NP-1:0]     rvalid_a, rvalid_b, rvalid_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NPORTS(NP),
                .RD_LATENCY(1), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .gnt(gnt_a), .rdata(rdata_a), .rvalid(rvalid_a));

  data_ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NPORTS(NP),
                .RD_LATENCY(1), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b));

  data_ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NPORTS(NP),
                .RD_LATENCY(2), .RDW_MODE(0)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .gnt(gnt_c), .rdata(rdata_c), .rvalid(rvalid_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req[p]            = r;
    we[p]             = w;
    wstrb[p*SW +: SW] = s;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    req = '0; we = '0; wstrb = '0; addr = '0; wdata = '0;
    #1 rst_n = 1'b0;
    tick(); tick();

    // Reset state.
    check("rst_rvalid_a", rvalid_a, 2'b00);
    check("rst_rdata_a",  rdata_a,  64'h0);
    check("rst_rvalid_c", rvalid_c, 2'b00);
    check("rst_rdata_c",  rdata_c,  64'h0);
    rst_n = 1'b1;
    tick();

    // Full-word write then read, port 0, addr 5.
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd5, 32'hDEADBEEF);
    #1 check("wr5_gnt", gnt_a, 2'b01);
    tick();
    check("wr5_no_rvalid", rvalid_a, 2'b00);
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd5, 32'h0);
    tick();
    check("rd5_rvalid_l1", rvalid_a, 2'b01);
    check("rd5_rdata_l1",  rdata_a[31:0], 32'hDEADBEEF);
    check("rd5_rvalid_l2_early", rvalid_c, 2'b00);
    idle();
    tick();
    check("rd5_rvalid_l1_drop", rvalid_a, 2'b00);
    check("rd5_rdata_l1_hold",  rdata_a[31:0], 32'hDEADBEEF);
    check("rd5_rvalid_l2", rvalid_c, 2'b01);
    check("rd5_rdata_l2",  rdata_c[31:0], 32'hDEADBEEF);
    tick();

    // Byte strobes at addr 9.
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd9, 32'h11223344);
    tick();
    set_port(0, 1'b1, 1'b1, 4'h5, 12'd9, 32'hAABBCCDD);
    tick();
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd9, 32'h0);
    tick();
    check("strb5_rdata", rdata_a[31:0], 32'h11BB33DD);
    set_port(0, 1'b1, 1'b1, 4'h0, 12'd9, 32'hFFFFFFFF);
    #1 check("strb0_gnt", gnt_a, 2'b01);
    tick();
    check("strb0_no_rvalid", rvalid_a, 2'b00);
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd9, 32'h0);
    tick();
    check("strb0_rdata", rdata_a[31:0], 32'h11BB33DD);
    idle();
    tick();

    // Same-address write collision at addr 3.
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd3, 32'h1);
    set_port(1, 1'b1, 1'b1, 4'hF, 12'd3, 32'h2);
    #1 check("coll_gnt_first", gnt_a, 2'b01);
    tick();
    set_port(0, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    #1 check("coll_gnt_second", gnt_a, 2'b10);
    tick();
    // Both ports read the same word in one cycle.
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd3, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'd3, 32'h0);
    #1 check("dual_rd_gnt", gnt_a, 2'b11);
    tick();
    check("dual_rd_rvalid", rvalid_a, 2'b11);
    check("dual_rd_rdata",  rdata_a, {32'h2, 32'h2});
    idle();
    tick();

    // Read during write at addr 7 (initially zero).
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd7, 32'hFFFFFFFF);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'd7, 32'h0);
    #1 check("rdw_gnt", gnt_a, 2'b11);
    tick();
    check("rdw_rvalid", rvalid_a, 2'b10);
    check("rdw_old",    rdata_a[63:32], 32'h0);
    check("rdw_new",    rdata_b[63:32], 32'hFFFFFFFF);
    set_port(0, 1'b1, 1'b1, 4'h3, 12'd7, 32'h12345678);
    tick();
    check("rdw_part_old", rdata_a[63:32], 32'hFFFFFFFF);
    check("rdw_part_new", rdata_b[63:32], 32'hFFFF5678);
    idle();
    tick();

    // Latency-2 streaming: fill addrs 0..3, then four back-to-back reads.
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd0, 32'hA0A00000);
    set_port(1, 1'b1, 1'b1, 4'hF, 12'd1, 32'hA0A00001);
    #1 check("fill_gnt", gnt_c, 2'b11);
    tick();
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd2, 32'hA0A00002);
    set_port(1, 1'b1, 1'b1, 4'hF, 12'd3, 32'hA0A00003);
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_port(0, 1'b1, 1'b0, 4'h0, 12'(i), 32'h0);
      else       idle();
      tick();
      check($sformatf("stream_l1_rvalid_%0d", i), rvalid_a, (i < 4) ? 2'b01 : 2'b00);
      if (i < 4)
        check($sformatf("stream_l1_rdata_%0d", i), rdata_a[31:0], 32'hA0A00000 + 32'(i));
      check($sformatf("stream_l2_rvalid_%0d", i), rvalid_c,
            (i >= 1 && i <= 4) ? 2'b01 : 2'b00);
      if (i >= 1 && i <= 4)
        check($sformatf("stream_l2_rdata_%0d", i), rdata_c[31:0], 32'hA0A00000 + 32'(i - 1));
    end

    // Reset with a read in flight in the latency-2 instance.
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd9, 32'h0);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("rstfl_rvalid_c", rvalid_c, 2'b00);
    check("rstfl_rdata_c",  rdata_c,  64'h0);
    check("rstfl_rdata_a",  rdata_a,  64'h0);
    tick();
    check("rstfl_rvalid_c_late", rvalid_c, 2'b00);
    // Release reset together with a write that takes the first live edge.
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b1, 4'hF, 12'd20, 32'hCAFEF00D);
    tick();
    check("rel_rvalid_a", rvalid_a, 2'b00);
    check("rel_rvalid_c", rvalid_c, 2'b00);
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd9, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 12'd5, 32'h0);
    tick();
    check("keep_rvalid_a", rvalid_a, 2'b11);
    check("keep_rdata_a",  rdata_a, {32'hDEADBEEF, 32'h11BB33DD});
    set_port(0, 1'b1, 1'b0, 4'h0, 12'd20, 32'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    tick();
    check("keep_rdata_c",  rdata_c, {32'hDEADBEEF, 32'h11BB33DD});
    check("rel_wr_rdata",  rdata_a[31:0], 32'hCAFEF00D);
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_ram_mp
